// File: rtl/cpu_pkg.sv
// Shared core types for the register-file write path: write-port payload, arbiter states, fixed register ids.
// Pure declarations, no logic.
package cpu_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;

  // Return-address register, also hard-wired in WB.
  localparam logic [RF_ADDR_W-1:0] RA_REG = 4'hF;

  typedef enum logic {
    ARB_NORMAL    = 1'b0,
    ARB_AUX_FORCE = 1'b1
  } Arb_State_e;

  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } Rf_Wr_t;

endpackage

// File: rtl/rf_wr_starve_ctr.sv
// Counts consecutive blocked aux cycles and raises force_aux for one grant after MAX_WAIT of them.
// Latency: force_aux is registered, asserted the cycle after the MAX_WAIT-th block; no backpressure of its own.
module rf_wr_starve_ctr
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic aux_valid,
  input  logic aux_ready,
  output logic force_aux
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  Arb_State_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             aux_fire;

  assign aux_fire = aux_valid & aux_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ARB_NORMAL;
      wait_cnt  <= '0;
      force_aux <= 1'b0;
    end else begin
      if (aux_fire || !aux_valid) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        ARB_NORMAL: begin
          if (aux_valid && !aux_ready && wait_cnt == WAIT_LAST) begin
            state     <= ARB_AUX_FORCE;
            force_aux <= 1'b1;
          end
        end
        ARB_AUX_FORCE: begin
          // A dropped request is a protocol error; fall back rather than stall WB forever.
          if (aux_fire || !aux_valid) begin
            state     <= ARB_NORMAL;
            force_aux <= 1'b0;
          end
        end
      endcase
    end
  end

  a_aux_hold : assert property (@(posedge Clk) disable iff (Rst)
    (state == ARB_AUX_FORCE) |-> aux_valid)
    else $error("aux request withdrawn while forced onto the write port");

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the RF write port between WB (priority) and an aux writer, with a starvation guard for aux.
// Latency 1 cycle to rf_wr_*; WB is back-pressured only for the single forced aux grant, aux waits while WB writes.
module rf_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wb_Valid_i,
  output logic              Wb_Ready_o,
  input  logic              Wb_WrEn_i,
  input  logic [ADDR_W-1:0] Wb_Addr_i,
  input  logic [DATA_W-1:0] Wb_Data_i,
  input  logic              Aux_Valid_i,
  output logic              Aux_Ready_o,
  input  logic [ADDR_W-1:0] Aux_Addr_i,
  input  logic [DATA_W-1:0] Aux_Data_i,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [STAT_W-1:0] Wb_Stall_Cnt_o
);

  if (DATA_W != RF_DATA_W || ADDR_W != RF_ADDR_W) begin : g_width_check
    $error("rf_wr_arbiter widths must match the Rf_Wr_t payload");
  end

  logic              force_aux;
  logic              wb_need;
  logic              wb_fire;
  logic              wb_wr;
  logic              aux_fire;
  Rf_Wr_t            wr_q;
  logic [STAT_W-1:0] stall_q;

  assign wb_need = Wb_Valid_i & Wb_WrEn_i;

  // Grants are held low during reset so nothing is consumed in the reset cycle.
  assign Wb_Ready_o  = !Rst & !force_aux;
  assign Aux_Ready_o = !Rst & Aux_Valid_i & (force_aux | !wb_need);

  assign wb_fire  = Wb_Valid_i & Wb_Ready_o;
  assign wb_wr    = wb_fire & Wb_WrEn_i;
  assign aux_fire = Aux_Valid_i & Aux_Ready_o;

  rf_wr_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .Clk       (Clk),
    .Rst       (Rst),
    .aux_valid (Aux_Valid_i),
    .aux_ready (Aux_Ready_o),
    .force_aux (force_aux)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_q <= '0;
    end else begin
      wr_q.en   <= wb_wr | aux_fire;
      wr_q.addr <= aux_fire ? Aux_Addr_i : Wb_Addr_i;
      wr_q.data <= aux_fire ? Aux_Data_i : Wb_Data_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_q <= '0;
    end else if (force_aux && Wb_Valid_i && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign rf_wr_en       = wr_q.en;
  assign rf_wr_addr     = wr_q.addr;
  assign rf_wr_data     = wr_q.data;
  assign Wb_Stall_Cnt_o = stall_q;

  a_one_writer : assert property (@(posedge Clk) disable iff (Rst)
    !(aux_fire && wb_wr))
    else $error("WB and aux both granted the write port");

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order WB stage, which has priority;
  - an auxiliary long-latency writer (multi-cycle MUL/DIV or late load return), which has lower priority.
- Starvation guard forces the aux writer onto the port after MAX_WAIT blocked cycles by back-pressuring WB.
- RF write outputs are registered.
- Sits between WB/aux units and the RF write port.

Parameters:
- DATA_W, 32, RF data width
- ADDR_W, 4, RF address width (16 regs)
- MAX_WAIT, 4, consecutive blocked aux cycles before WB is stalled (>=1)
- STAT_W, 16, width of the saturating WB-stall statistic counter

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- Wb_Valid_i  in  1  WB request valid
- Wb_Ready_o  out  1  WB request accepted
- Wb_WrEn_i  in  1  WB transaction writes RF (isWb)
- Wb_Addr_i  in  ADDR_W  WB destination register
- Wb_Data_i  in  DATA_W  WB write data
- Aux_Valid_i  in  1  aux request valid (must hold until handshake)
- Aux_Ready_o  out  1  aux request accepted
- Aux_Addr_i  in  ADDR_W  aux destination register
- Aux_Data_i  in  DATA_W  aux write data
- rf_wr_en  out  1  RF write enable
- rf_wr_addr  out  ADDR_W  RF write address
- rf_wr_data  out  DATA_W  RF write data
- Wb_Stall_Cnt_o  out  STAT_W  cycles WB was stalled by force (saturating)

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst.
- Reset values:
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0;
  - state=ARB_NORMAL, wait_cnt=0, Wb_Stall_Cnt_o=0.
- Definitions:
  - wb_need = Wb_Valid_i & Wb_WrEn_i;
  - wb_fire = Wb_Valid_i & Wb_Ready_o;
  - aux_fire = Aux_Valid_i & Aux_Ready_o.
- Combinational grant, no combinational path from Aux_* to Wb_Ready_o except through state:
  - ARB_NORMAL: Wb_Ready_o=1; Aux_Ready_o = Aux_Valid_i & !wb_need.
  - ARB_AUX_FORCE: Wb_Ready_o=0; Aux_Ready_o = Aux_Valid_i.
- WB transaction with Wb_WrEn_i=0:
  - consumed (wb_fire) without using the port;
  - the aux writer may use the port in the same cycle.
- Write register, latency 1 cycle:
  - rf_wr_en <= (wb_fire & Wb_WrEn_i) | aux_fire.
  - addr/data <= aux payload if aux_fire, else WB payload.
  - addr/data update every cycle; they are don't-care when en=0 but must be deterministic.
  - aux_fire and (wb_fire & Wb_WrEn_i) are never both true; assert this.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - cleared on aux_fire or when !Aux_Valid_i;
  - incremented when Aux_Valid_i & !Aux_Ready_o.
- FSM:
  - ARB_NORMAL -> ARB_AUX_FORCE when Aux_Valid_i & !Aux_Ready_o & wait_cnt==MAX_WAIT-1, i.e. after MAX_WAIT blocked cycles.
  - ARB_AUX_FORCE -> ARB_NORMAL on aux_fire, which is the same cycle as entry+1 since Aux_Ready_o=1.
  - ARB_AUX_FORCE -> ARB_NORMAL if Aux_Valid_i drops (protocol violation; flag via assertion, recover cleanly).
- Wb_Stall_Cnt_o:
  - +1 each cycle in ARB_AUX_FORCE with Wb_Valid_i=1;
  - saturates at all-ones, no wrap.
- Ordering: WAW between writers is prevented by issue logic. The arbiter does not compare addresses. Same-address requests are arbitrated by the rules above only.
- Reset mid-FORCE returns to ARB_NORMAL:
  - pending aux is not accepted in the reset cycle;
  - no write occurs the cycle after reset.

Decomposition:
- cpu_pkg additions:
  - Rf_Wr_t struct {en, addr[ADDR_W], data[DATA_W]};
  - Arb_State_e enum {ARB_NORMAL, ARB_AUX_FORCE};
  - RA_REG=4'hF constant (shared with WB).
- One sub-module: rf_wr_starve_ctr.
  - Contains wait_cnt and the FSM; outputs force.
  - Top holds grant logic, write register and stat counter.

Test Plan (MAX_WAIT=4):
- Rst=1 for 2 cycles, inputs random -> rf_wr_en=0, addr=0, data=0, Wb_Stall_Cnt_o=0, Wb_Ready_o=1 after release.
- Cycle t: Wb_Valid=1, WrEn=1, Addr=3, Data=32'hDEADBEEF, no aux -> t+1: rf_wr_en=1, rf_wr_addr=3, rf_wr_data=DEADBEEF.
- Continuous WB writes plus Aux_Valid=1 (Addr=5, Data=32'h1234) from t -> aux blocked t..t+3; t+4: Wb_Ready_o=0, Aux_Ready_o=1; t+5: rf write r5=0x1234, Wb_Stall_Cnt_o=1, Wb_Ready_o=1.
- Wb_Valid=1 with WrEn=0 and aux valid (Addr=7, Data=9) same cycle -> both handshakes fire; next cycle rf write r7=9.
- Enter ARB_AUX_FORCE, assert Rst in the force cycle -> no aux_fire; next cycle rf_wr_en=0, state ARB_NORMAL, wait_cnt=0.
- STAT_W=2, four forced stalls with Wb_Valid=1 -> Wb_Stall_Cnt_o saturates at 3.
